// File: rtl/tv_sync_gen.sv
// Composite-video timing generator: composite sync, blanking/burst gates, field flag,
// PAL line-alternation phase and position counters, with external vertical resync.
module tv_sync_gen #(
  parameter int HL          = 768,
  parameter int FIELD_HL    = 625,
  parameter int SYNC_W      = 114,
  parameter int NARROW_W    = 56,
  parameter int BROAD_W     = 655,
  parameter int BROAD_HL    = 5,
  parameter int EQ_PRE      = 5,
  parameter int EQ_POST     = 7,
  parameter int BURST_START = 138,
  parameter int BURST_W     = 75,
  parameter int BLANK_END   = 249,
  parameter int BLANK_START = 1496
) (
  input  logic        clk24,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        interlace,
  input  logic        field_alt_en,
  input  logic        resync,
  output logic        sync_n,
  output logic        blank,
  output logic        burst,
  output logic        field,
  output logic        chroma_alt,
  output logic        line_start,
  output logic        field_start,
  output logic [11:0] hpos,
  output logic [9:0]  halfline
);

  localparam logic [11:0] HC_HALF_LAST = 12'(HL - 1);
  localparam logic [11:0] HC_LAST      = 12'(2 * HL - 1);
  localparam logic [11:0] HL_LEN       = 12'(HL);
  localparam logic [11:0] SYNC_LEN     = 12'(SYNC_W);
  localparam logic [11:0] NARROW_LEN   = 12'(NARROW_W);
  localparam logic [11:0] BROAD_LEN    = 12'(BROAD_W);
  localparam logic [11:0] BURST_LO     = 12'(BURST_START);
  localparam logic [11:0] BURST_HI     = 12'(BURST_START + BURST_W);
  localparam logic [11:0] BLANK_LO     = 12'(BLANK_END);
  localparam logic [11:0] BLANK_HI     = 12'(BLANK_START);
  localparam logic [9:0]  BROAD_END    = 10'(BROAD_HL);
  localparam logic [9:0]  EQ_PRE_END   = 10'(BROAD_HL + EQ_PRE);
  localparam logic [9:0]  FLEN_ILACE   = 10'(FIELD_HL);
  localparam logic [9:0]  FLEN_PROG    = 10'(FIELD_HL - 1);
  localparam logic [9:0]  EQ_POST_LEN  = 10'(EQ_POST);

  logic [11:0] hc;
  logic [9:0]  hlc;
  logic        fld;
  logic        rs_q;

  logic [9:0]  flen;
  logic [9:0]  flen_last;
  logic [9:0]  eq_post_start;
  logic [11:0] hp;
  logic        hl_bound;
  logic        field_end;
  logic        rs_fall;
  logic        zone_broad;
  logic        zone_narrow;
  logic        sync_low;
  logic        burst_on;
  logic        blank_on;

  always_comb begin
    flen          = interlace ? FLEN_ILACE : FLEN_PROG;
    flen_last     = flen - 10'd1;
    eq_post_start = flen - EQ_POST_LEN;
    hp            = (hc < HL_LEN) ? hc : hc - HL_LEN;
    hl_bound      = (hc == HC_HALF_LAST) || (hc == HC_LAST);
    // >= rather than == so a mid-field switch to a shorter field still terminates
    field_end     = hl_bound && (hlc >= flen_last);
    rs_fall       = rs_q & ~resync;
    zone_broad    = hlc < BROAD_END;
    zone_narrow   = !zone_broad && ((hlc < EQ_PRE_END) || (hlc >= eq_post_start));
  end

  always_comb begin
    sync_low = 1'b0;
    if (zone_broad)
      sync_low = hp < BROAD_LEN;
    else if (zone_narrow)
      sync_low = hp < NARROW_LEN;
    else
      sync_low = hc < SYNC_LEN;
    burst_on = !(zone_broad || zone_narrow) && (hc > BURST_LO) && (hc < BURST_HI);
    blank_on = zone_broad || zone_narrow || (hc < BLANK_LO) || (hc > BLANK_HI);
  end

  // Resync wins over wrap/field end so fld toggles only once on a coincident edge.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      hc   <= '0;
      hlc  <= '0;
      fld  <= 1'b0;
      rs_q <= 1'b1;
    end else if (ce) begin
      rs_q <= resync;
      if (rs_fall) begin
        hc  <= '0;
        hlc <= '0;
        fld <= ~fld;
      end else begin
        hc <= (hc == HC_LAST) ? 12'd0 : hc + 12'd1;
        if (field_end) begin
          hlc <= '0;
          fld <= ~fld;
        end else if (hl_bound) begin
          hlc <= hlc + 10'd1;
        end
      end
    end
  end

  // field_start marks the first clock of half-line 0; on odd-length fields that
  // alternates between hpos=0 and hpos=HL because hc is never reset at field end.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      sync_n      <= 1'b1;
      blank       <= 1'b1;
      burst       <= 1'b0;
      field       <= 1'b0;
      chroma_alt  <= 1'b0;
      line_start  <= 1'b0;
      field_start <= 1'b0;
      hpos        <= '0;
      halfline    <= '0;
    end else if (ce) begin
      sync_n      <= ~sync_low;
      blank       <= blank_on;
      burst       <= burst_on;
      field       <= fld;
      chroma_alt  <= hlc[1] ^ (field_alt_en & fld);
      line_start  <= (hc == 12'd0);
      field_start <= (hlc == 10'd0) && (hp == 12'd0);
      hpos        <= hc;
      halfline    <= hlc;
    end
  end

endmodule

// File: tb/tb_tv_sync_gen.sv
// Directed bench for tv_sync_gen using a scaled timing set (40-clock half-lines,
// 25 half-line fields) so several whole fields fit in a short run.
module tb_tv_sync_gen;

  logic        clk24 = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b0;
  logic        interlace = 1'b1;
  logic        field_alt_en = 1'b0;
  logic        resync = 1'b1;
  logic        sync_n, blank, burst, field, chroma_alt, line_start, field_start;
  logic [11:0] hpos;
  logic [9:0]  halfline;

  int errors = 0;
  int checks = 0;
  int ncyc = 0;

  tv_sync_gen #(
    .HL(40), .FIELD_HL(25), .SYNC_W(6), .NARROW_W(3), .BROAD_W(34),
    .BROAD_HL(5), .EQ_PRE(5), .EQ_POST(7), .BURST_START(7), .BURST_W(4),
    .BLANK_END(13), .BLANK_START(77)
  ) dut (
    .clk24(clk24), .reset_n(reset_n), .ce(ce), .interlace(interlace),
    .field_alt_en(field_alt_en), .resync(resync), .sync_n(sync_n), .blank(blank),
    .burst(burst), .field(field), .chroma_alt(chroma_alt), .line_start(line_start),
    .field_start(field_start), .hpos(hpos), .halfline(halfline)
  );

  always #5 clk24 = ~clk24;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk24);
    @(negedge clk24);
    ncyc++;
  endtask

  task automatic tick_to(input int n);
    while (ncyc < n) tick();
  endtask

  task automatic do_reset(input logic il, input logic fae);
    ce = 1'b1; resync = 1'b1; interlace = il; field_alt_en = fae;
    reset_n = 1'b0;
    @(negedge clk24);
    @(negedge clk24);
    reset_n = 1'b1;
    ncyc = 0;
  endtask

  task automatic test_reset();
    ce = 1'b1; resync = 1'b1; interlace = 1'b1; field_alt_en = 1'b0;
    reset_n = 1'b0;
    @(negedge clk24);
    @(negedge clk24);
    checks++;
    if (sync_n !== 1'b1 || blank !== 1'b1 || burst !== 1'b0 || field !== 1'b0 ||
        chroma_alt !== 1'b0 || line_start !== 1'b0 || field_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got sync_n=%b blank=%b burst=%b field=%b calt=%b ls=%b fs=%b want 1 1 0 0 0 0 0",
               sync_n, blank, burst, field, chroma_alt, line_start, field_start);
    end
    checks++;
    if (hpos !== 12'd0 || halfline !== 10'd0) begin
      errors++;
      $display("FAIL reset_pos: got hpos=%0d halfline=%0d want 0 0", hpos, halfline);
    end
    reset_n = 1'b1;
    ncyc = 0;
    tick();
    checks++;
    if (hpos !== 12'd0 || halfline !== 10'd0 || line_start !== 1'b1 || field_start !== 1'b1) begin
      errors++;
      $display("FAIL first_ce_pos: got hpos=%0d halfline=%0d ls=%b fs=%b want 0 0 1 1",
               hpos, halfline, line_start, field_start);
    end
    checks++;
    if (sync_n !== 1'b0 || blank !== 1'b1 || burst !== 1'b0 || field !== 1'b0) begin
      errors++;
      $display("FAIL first_ce_gates: got sync_n=%b blank=%b burst=%b field=%b want 0 1 0 0",
               sync_n, blank, burst, field);
    end
  endtask

  task automatic test_normal_line();
    logic exp_sync, exp_burst, exp_blank;
    do_reset(1'b1, 1'b0);
    tick_to(480);
    for (int i = 0; i < 80; i++) begin
      tick();
      exp_sync  = !(i < 6);
      exp_burst = (i > 7) && (i < 11);
      exp_blank = (i < 13) || (i > 77);
      checks++;
      if (hpos !== 12'(i) || halfline !== 10'(i < 40 ? 12 : 13)) begin
        errors++;
        $display("FAIL line_pos: got hpos=%0d halfline=%0d want %0d %0d",
                 hpos, halfline, i, (i < 40 ? 12 : 13));
      end
      checks++;
      if (sync_n !== exp_sync || burst !== exp_burst || blank !== exp_blank) begin
        errors++;
        $display("FAIL line_gates at hpos %0d: got sync_n=%b burst=%b blank=%b want %b %b %b",
                 i, sync_n, burst, blank, exp_sync, exp_burst, exp_blank);
      end
    end
  endtask

  task automatic test_field_zone();
    int low_run, low_tot, burst_cnt, blank_cnt, exp_low, exp_burst, exp_blank;
    do_reset(1'b1, 1'b0);
    for (int hl = 0; hl < 25; hl++) begin
      low_run = 0; low_tot = 0; burst_cnt = 0; blank_cnt = 0;
      for (int p = 0; p < 40; p++) begin
        tick();
        checks++;
        if (hpos !== 12'(p + 40 * (hl % 2)) || halfline !== 10'(hl)) begin
          errors++;
          $display("FAIL zone_pos: got hpos=%0d halfline=%0d want %0d %0d",
                   hpos, halfline, p + 40 * (hl % 2), hl);
        end
        if (!sync_n) begin
          low_tot++;
          if (low_run == p) low_run++;
        end
        if (burst) burst_cnt++;
        if (blank) blank_cnt++;
      end
      if (hl < 5) begin
        exp_low = 34; exp_burst = 0; exp_blank = 40;
      end else if (hl < 10 || hl >= 18) begin
        exp_low = 3; exp_burst = 0; exp_blank = 40;
      end else if (hl % 2 == 0) begin
        exp_low = 6; exp_burst = 3; exp_blank = 13;
      end else begin
        exp_low = 0; exp_burst = 0; exp_blank = 2;
      end
      checks++;
      if (low_run != exp_low || low_tot != exp_low) begin
        errors++;
        $display("FAIL zone_sync hl %0d: got run=%0d total=%0d want %0d", hl, low_run, low_tot, exp_low);
      end
      checks++;
      if (burst_cnt != exp_burst) begin
        errors++;
        $display("FAIL zone_burst hl %0d: got %0d want %0d", hl, burst_cnt, exp_burst);
      end
      checks++;
      if (blank_cnt != exp_blank) begin
        errors++;
        $display("FAIL zone_blank hl %0d: got %0d want %0d", hl, blank_cnt, exp_blank);
      end
    end
  endtask

  task automatic test_free_run();
    int k, last_ls, ls_count;
    do_reset(1'b1, 1'b0);
    k = 0; last_ls = 0; ls_count = 0;
    for (int i = 0; i < 3300; i++) begin
      tick();
      if (field_start) begin
        checks++;
        if (ncyc != 1 + 1000 * k || field !== 1'(k % 2) || hpos !== 12'((k % 2) * 40)) begin
          errors++;
          $display("FAIL free_field_start %0d: got cycle=%0d field=%b hpos=%0d want %0d %0d %0d",
                   k, ncyc, field, hpos, 1 + 1000 * k, k % 2, (k % 2) * 40);
        end
        k++;
      end
      if (line_start) begin
        if (last_ls != 0) begin
          checks++;
          if (ncyc - last_ls != 80) begin
            errors++;
            $display("FAIL free_line_period: got %0d want 80", ncyc - last_ls);
          end
        end
        last_ls = ncyc;
        ls_count++;
      end
    end
    checks++;
    if (k != 4 || ls_count != 42) begin
      errors++;
      $display("FAIL free_counts: got fields=%0d lines=%0d want 4 42", k, ls_count);
    end
  endtask

  task automatic test_progressive();
    int k;
    do_reset(1'b0, 1'b0);
    k = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (field_start) begin
        checks++;
        if (ncyc != 1 + 960 * k || hpos !== 12'd0 || line_start !== 1'b1 || field !== 1'(k % 2)) begin
          errors++;
          $display("FAIL prog_field_start %0d: got cycle=%0d hpos=%0d ls=%b field=%b want %0d 0 1 %0d",
                   k, ncyc, hpos, line_start, field, 1 + 960 * k, k % 2);
        end
        k++;
      end
    end
    checks++;
    if (k != 4) begin
      errors++;
      $display("FAIL prog_count: got %0d want 4", k);
    end
  endtask

  task automatic test_interlace_change();
    do_reset(1'b1, 1'b0);
    tick_to(930);
    interlace = 1'b0;
    tick_to(960);
    checks++;
    if (hpos !== 12'd79 || halfline !== 10'd23 || field !== 1'b0) begin
      errors++;
      $display("FAIL ilace_before: got hpos=%0d halfline=%0d field=%b want 79 23 0", hpos, halfline, field);
    end
    tick();
    checks++;
    if (hpos !== 12'd0 || halfline !== 10'd0 || field !== 1'b1 || field_start !== 1'b1) begin
      errors++;
      $display("FAIL ilace_after: got hpos=%0d halfline=%0d field=%b fs=%b want 0 0 1 1",
               hpos, halfline, field, field_start);
    end
  endtask

  task automatic test_resync();
    do_reset(1'b1, 1'b0);
    tick_to(581);
    checks++;
    if (hpos !== 12'd20 || halfline !== 10'd14) begin
      errors++;
      $display("FAIL resync_pre: got hpos=%0d halfline=%0d want 20 14", hpos, halfline);
    end
    resync = 1'b0;
    tick();
    checks++;
    if (hpos !== 12'd21 || halfline !== 10'd14 || field !== 1'b0) begin
      errors++;
      $display("FAIL resync_lat: got hpos=%0d halfline=%0d field=%b want 21 14 0", hpos, halfline, field);
    end
    tick();
    checks++;
    if (hpos !== 12'd0 || halfline !== 10'd0 || field !== 1'b1 || field_start !== 1'b1 ||
        line_start !== 1'b1 || sync_n !== 1'b0) begin
      errors++;
      $display("FAIL resync_restart: got hpos=%0d halfline=%0d field=%b fs=%b ls=%b sync_n=%b want 0 0 1 1 1 0",
               hpos, halfline, field, field_start, line_start, sync_n);
    end
    resync = 1'b1;
    repeat (5) tick();
    checks++;
    if (hpos !== 12'd5 || field !== 1'b1 || field_start !== 1'b0) begin
      errors++;
      $display("FAIL resync_after: got hpos=%0d field=%b fs=%b want 5 1 0", hpos, field, field_start);
    end
    // falling edge landing exactly on the natural field end
    do_reset(1'b1, 1'b0);
    tick_to(999);
    resync = 1'b0;
    tick();
    checks++;
    if (hpos !== 12'd39 || halfline !== 10'd24 || field !== 1'b0) begin
      errors++;
      $display("FAIL resync_end_lat: got hpos=%0d halfline=%0d field=%b want 39 24 0", hpos, halfline, field);
    end
    tick();
    checks++;
    if (hpos !== 12'd0 || halfline !== 10'd0 || field !== 1'b1 || field_start !== 1'b1) begin
      errors++;
      $display("FAIL resync_end_restart: got hpos=%0d halfline=%0d field=%b fs=%b want 0 0 1 1",
               hpos, halfline, field, field_start);
    end
    resync = 1'b1;
    tick();
    checks++;
    if (hpos !== 12'd1 || field !== 1'b1) begin
      errors++;
      $display("FAIL resync_end_after: got hpos=%0d field=%b want 1 1", hpos, field);
    end
  endtask

  task automatic test_chroma_alt();
    do_reset(1'b1, 1'b1);
    tick_to(161);
    checks++;
    if (halfline !== 10'd4 || chroma_alt !== 1'b0) begin
      errors++;
      $display("FAIL calt_f0_hl4: got halfline=%0d calt=%b want 4 0", halfline, chroma_alt);
    end
    tick_to(241);
    checks++;
    if (halfline !== 10'd6 || chroma_alt !== 1'b1) begin
      errors++;
      $display("FAIL calt_f0_hl6: got halfline=%0d calt=%b want 6 1", halfline, chroma_alt);
    end
    tick_to(1161);
    checks++;
    if (halfline !== 10'd4 || field !== 1'b1 || chroma_alt !== 1'b1) begin
      errors++;
      $display("FAIL calt_f1_hl4: got halfline=%0d field=%b calt=%b want 4 1 1", halfline, field, chroma_alt);
    end
    tick_to(1241);
    checks++;
    if (halfline !== 10'd6 || chroma_alt !== 1'b0) begin
      errors++;
      $display("FAIL calt_f1_hl6: got halfline=%0d calt=%b want 6 0", halfline, chroma_alt);
    end
    field_alt_en = 1'b0;
    tick();
    checks++;
    if (halfline !== 10'd6 || field !== 1'b1 || chroma_alt !== 1'b1) begin
      errors++;
      $display("FAIL calt_disabled: got halfline=%0d field=%b calt=%b want 6 1 1", halfline, field, chroma_alt);
    end
  endtask

  task automatic test_ce_hold();
    do_reset(1'b1, 1'b0);
    tick_to(484);
    ce = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk24);
      @(negedge clk24);
      checks++;
      if (hpos !== 12'd3 || halfline !== 10'd12 || sync_n !== 1'b0 || blank !== 1'b1 ||
          burst !== 1'b0 || line_start !== 1'b0 || field_start !== 1'b0 || field !== 1'b0 ||
          chroma_alt !== 1'b0) begin
        errors++;
        $display("FAIL ce_hold %0d: got hpos=%0d hl=%0d sync_n=%b blank=%b burst=%b ls=%b fs=%b field=%b calt=%b want 3 12 0 1 0 0 0 0 0",
                 i, hpos, halfline, sync_n, blank, burst, line_start, field_start, field, chroma_alt);
      end
    end
    ce = 1'b1;
    tick();
    checks++;
    if (hpos !== 12'd4 || sync_n !== 1'b0) begin
      errors++;
      $display("FAIL ce_resume: got hpos=%0d sync_n=%b want 4 0", hpos, sync_n);
    end
    tick();
    tick();
    checks++;
    if (hpos !== 12'd6 || sync_n !== 1'b1) begin
      errors++;
      $display("FAIL sync_edge: got hpos=%0d sync_n=%b want 6 1", hpos, sync_n);
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b1, 1'b0);
    tick_to(2);
    checks++;
    if (hpos !== 12'd1 || sync_n !== 1'b0) begin
      errors++;
      $display("FAIL async_pre: got hpos=%0d sync_n=%b want 1 0", hpos, sync_n);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (sync_n !== 1'b1 || hpos !== 12'd0 || blank !== 1'b1 || burst !== 1'b0 || line_start !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got sync_n=%b hpos=%0d blank=%b burst=%b ls=%b want 1 0 1 0 0",
               sync_n, hpos, blank, burst, line_start);
    end
    @(negedge clk24);
    reset_n = 1'b1;
    ncyc = 0;
    tick();
    checks++;
    if (hpos !== 12'd0 || field_start !== 1'b1 || sync_n !== 1'b0) begin
      errors++;
      $display("FAIL async_restart: got hpos=%0d fs=%b sync_n=%b want 0 1 0", hpos, field_start, sync_n);
    end
  endtask

  initial begin
    @(negedge clk24);
    test_reset();
    test_normal_line();
    test_field_zone();
    test_free_run();
    test_progressive();
    test_interlace_change();
    test_resync();
    test_chroma_alt();
    test_ce_hold();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
